// File: rtl/ps2_time_entry.sv
// ps2_time_entry: PS/2 scan-code numeric entry into NFIELD time fields; define LIVE_UPDATE_EN to commit while typing
module ps2_time_entry #(
  parameter int NFIELD = 6,
  parameter int SELW = 3,
  parameter int DIGITS = 2,
  parameter int VW = 7,
  parameter logic [8*NFIELD-1:0] MAX_PACK = {8'd59, 8'd59, 8'd23, 8'd59, 8'd59, 8'd23}
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic [7:0]           data,
  input  logic                 ready,
  input  logic                 overflow,
  output logic                 nextdata_n,
  input  logic                 edit_en,
  input  logic [SELW-1:0]      edit_sel,
  output logic [NFIELD*VW-1:0] field_val,
  output logic [4*DIGITS-1:0]  edit_buf,
  output logic                 commit,
  output logic                 err
);
  localparam int BW = 4*DIGITS;
  localparam int VV = VW+4;
  localparam int CW = $clog2(DIGITS+1);
  typedef enum logic [1:0] {IDLE, POP, WAIT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic brk, ext, en_q, ovf_seen, sel_chg, active, cur_ok;
  logic [SELW-1:0] sel_q;
  logic [4:0] kd;
  logic [BW-1:0] nbuf;
  logic [7:0] max_v;
  logic [VV-1:0] v_cur;
`ifdef LIVE_UPDATE_EN
  logic [VV-1:0] v_new;
  logic new_ok;
`endif
  function automatic logic [4:0] key_digit(input logic [7:0] b);
    case (b)
      8'h45, 8'h70: key_digit = 5'h10;
      8'h16, 8'h69: key_digit = 5'h11;
      8'h1E, 8'h72: key_digit = 5'h12;
      8'h26, 8'h7A: key_digit = 5'h13;
      8'h25, 8'h6B: key_digit = 5'h14;
      8'h2E, 8'h73: key_digit = 5'h15;
      8'h36, 8'h74: key_digit = 5'h16;
      8'h3D, 8'h6C: key_digit = 5'h17;
      8'h3E, 8'h75: key_digit = 5'h18;
      8'h46, 8'h7D: key_digit = 5'h19;
      default:      key_digit = 5'h00;
    endcase
  endfunction
  function automatic logic [VV-1:0] dec(input logic [BW-1:0] b);
    dec = '0;
    for (int k = DIGITS-1; k >= 0; k--) dec = VV'(dec * 10 + b[4*k +: 4]);
  endfunction
  assign sel_chg = (edit_sel != sel_q) || (en_q && !edit_en);
  always_comb begin
    kd = key_digit(data);
    nbuf = kd[4] ? BW'({edit_buf, kd[3:0]}) : edit_buf >> 4;
    active = edit_en && ({1'b0, edit_sel} < (SELW+1)'(NFIELD)) && !sel_chg;
    max_v = 8'(MAX_PACK >> (8*edit_sel));
    v_cur = dec(edit_buf);
    cur_ok = v_cur <= VV'(max_v);
`ifdef LIVE_UPDATE_EN
    v_new = dec(nbuf);
    new_ok = v_new <= VV'(max_v);
`endif
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      nextdata_n <= 1'b1;
      commit <= 1'b0;
      err <= 1'b0;
      field_val <= '0;
      edit_buf <= '0;
      cnt <= '0;
      brk <= 1'b0;
      ext <= 1'b0;
      sel_q <= '0;
      en_q <= 1'b0;
      ovf_seen <= 1'b0;
    end else begin
      commit <= 1'b0;
      err <= 1'b0;
      sel_q <= edit_sel;
      en_q <= edit_en;
      if (!overflow) ovf_seen <= 1'b0;
      if (sel_chg) begin
        edit_buf <= '0;
        cnt <= '0;
      end
      case (state)
        IDLE: begin
          if (overflow) begin
            brk <= 1'b0;
            ext <= 1'b0;
            edit_buf <= '0;
            cnt <= '0;
            if (!ovf_seen) begin
              err <= 1'b1;
              ovf_seen <= 1'b1;
            end
          end
          if (ready) begin
            nextdata_n <= 1'b0;
            state <= POP;
            if (!overflow) begin
              if (data == 8'hF0) brk <= 1'b1;
              else if (data == 8'hE0) ext <= 1'b1;
              else begin
                brk <= 1'b0;
                ext <= 1'b0;
                if (!brk && active) begin
                  if (!ext && (kd[4] || data == 8'h66)) begin
                    edit_buf <= nbuf;
                    cnt <= kd[4] ? (cnt == CW'(DIGITS) ? cnt : cnt + 1'b1) : (cnt == '0 ? cnt : cnt - 1'b1);
`ifdef LIVE_UPDATE_EN
                    if (new_ok) begin
                      field_val[VW*edit_sel +: VW] <= v_new[VW-1:0];
                      commit <= 1'b1;
                    end
`endif
                  end else if (!ext && data == 8'h76) begin
                    edit_buf <= '0;
                    cnt <= '0;
                  end else if (data == 8'h5A) begin
                    edit_buf <= '0;
                    cnt <= '0;
`ifdef LIVE_UPDATE_EN
                    if (!cur_ok) err <= 1'b1;
`else
                    if (cur_ok) begin
                      field_val[VW*edit_sel +: VW] <= v_cur[VW-1:0];
                      commit <= 1'b1;
                    end else err <= 1'b1;
`endif
                  end
                end
              end
            end
          end
        end
        POP: begin
          nextdata_n <= 1'b1;
          state <= WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_time_entry.sv
// tb_ps2_time_entry: directed checks of byte handshake, digit entry, Enter range check and reset
module tb_ps2_time_entry;
  logic clk = 1'b0, clrn = 1'b0, ready = 1'b0, overflow = 1'b0, edit_en = 1'b1;
  logic [7:0] data = 8'h00;
  logic [2:0] edit_sel = 3'd0;
  logic nextdata_n, commit, err;
  logic [41:0] field_val;
  logic [7:0] edit_buf;
  int checks = 0, failures = 0;
  int commit_cnt = 0, err_cnt = 0, both_cnt = 0, pop_cnt = 0, run = 0, max_run = 0;
  int c0, e0, p0;
  logic c_s, e_s, got;
  ps2_time_entry dut (
    .clk(clk), .clrn(clrn), .data(data), .ready(ready), .overflow(overflow),
    .nextdata_n(nextdata_n), .edit_en(edit_en), .edit_sel(edit_sel),
    .field_val(field_val), .edit_buf(edit_buf), .commit(commit), .err(err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (commit) commit_cnt++;
    if (err) err_cnt++;
    if (commit && err) both_cnt++;
    if (!nextdata_n) begin
      pop_cnt++;
      run++;
      if (run > max_run) max_run = run;
    end else run = 0;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    data = b;
    ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (!nextdata_n) got = 1'b1;
    end
    c_s = commit;
    e_s = err;
    if (!got) chk("pop_timeout", 0, 1);
    ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  function automatic logic [6:0] fld(input int i);
    return field_val[7*i +: 7];
  endfunction
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_nextdata_n", nextdata_n, 1);
    chk("rst_commit", commit, 0);
    chk("rst_err", err, 0);
    chk("rst_field_val", field_val, 0);
    chk("rst_edit_buf", edit_buf, 0);
    clrn = 1'b1;
    repeat (2) @(negedge clk);
    // 1: field0 (max 23) with break codes interleaved
    c0 = commit_cnt; p0 = pop_cnt;
    send(8'h1E); send(8'hF0); send(8'h1E); send(8'h26);
    chk("t1_buf", edit_buf, 8'h23);
    send(8'hF0); send(8'h26); send(8'h5A);
    chk("t1_field0", fld(0), 23);
    chk("t1_buf_clr", edit_buf, 0);
    chk("t1_pops", pop_cnt - p0, 7);
    chk("t1_low_run", max_run, 1);
`ifdef LIVE_UPDATE_EN
    chk("t1_commits", commit_cnt - c0, 2);
`else
    chk("t1_commits", commit_cnt - c0, 1);
`endif
    // 2: field1 (max 59), 67 is out of range
    edit_sel = 3'd1;
    repeat (2) @(negedge clk);
    c0 = commit_cnt; e0 = err_cnt;
    send(8'h36); send(8'h3D);
    chk("t2_buf", edit_buf, 8'h67);
    send(8'h5A);
    chk("t2_err_pulse", e_s, 1);
    chk("t2_errs", err_cnt - e0, 1);
    chk("t2_buf_clr", edit_buf, 0);
`ifdef LIVE_UPDATE_EN
    chk("t2_field1", fld(1), 6);
    chk("t2_commits", commit_cnt - c0, 1);
`else
    chk("t2_field1", fld(1), 0);
    chk("t2_commits", commit_cnt - c0, 0);
`endif
    // 3: keypad digits and extended Enter into field2
    edit_sel = 3'd2;
    repeat (2) @(negedge clk);
    send(8'h73); send(8'h69);
    chk("t3_buf", edit_buf, 8'h51);
    send(8'hE0); send(8'h5A);
    chk("t3_field2", fld(2), 51);
`ifdef LIVE_UPDATE_EN
    chk("t3_enter_commit", c_s, 0);
`else
    chk("t3_enter_commit", c_s, 1);
`endif
    send(8'hE0); send(8'h75);
    chk("t3_up_arrow_ignored", edit_buf, 0);
    chk("t3_field2_kept", fld(2), 51);
    // 4: overflow of the digit window, Backspace, Escape
    edit_sel = 3'd0;
    repeat (2) @(negedge clk);
    send(8'h16); send(8'h1E); send(8'h26);
    chk("t4_buf_shift", edit_buf, 8'h23);
    send(8'h66);
    chk("t4_buf_bs", edit_buf, 8'h02);
    send(8'h5A);
    chk("t4_field0", fld(0), 2);
    send(8'h16); send(8'h76);
    chk("t4_buf_esc", edit_buf, 0);
    send(8'h5A);
`ifdef LIVE_UPDATE_EN
    chk("t4_field0_esc", fld(0), 1);
    chk("t4_esc_commit", c_s, 0);
`else
    chk("t4_field0_esc", fld(0), 0);
    chk("t4_esc_commit", c_s, 1);
`endif
    // gating: bytes are popped but ignored while entry is disabled
    edit_en = 1'b0;
    repeat (2) @(negedge clk);
    p0 = pop_cnt;
    send(8'h1E);
    chk("gate_buf", edit_buf, 0);
    chk("gate_pop", pop_cnt - p0, 1);
    edit_en = 1'b1;
    repeat (2) @(negedge clk);
    // FIFO overflow: one err per rising edge, buffer cleared
    send(8'h1E);
    chk("ovf_buf_pre", edit_buf, 8'h02);
    e0 = err_cnt;
    overflow = 1'b1;
    repeat (5) @(negedge clk);
    overflow = 1'b0;
    chk("ovf_err_once", err_cnt - e0, 1);
    chk("ovf_buf_clr", edit_buf, 0);
    @(negedge clk);
    overflow = 1'b1;
    repeat (2) @(negedge clk);
    overflow = 1'b0;
    @(negedge clk);
    chk("ovf_err_again", err_cnt - e0, 2);
    // 5: async reset mid-entry, while the pop strobe is low
    send(8'h16);
    chk("t5_buf_pre", edit_buf, 8'h01);
    data = 8'h1E;
    ready = 1'b1;
    @(negedge clk);
    chk("t5_pop_low", nextdata_n, 0);
    clrn = 1'b0;
    #1;
    chk("t5_nextdata_n_async", nextdata_n, 1);
    ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_field_val", field_val, 0);
    chk("t5_edit_buf", edit_buf, 0);
    chk("t5_commit", commit, 0);
    chk("t5_err", err, 0);
    clrn = 1'b1;
    repeat (2) @(negedge clk);
    // 6: field1 typed 5,3,3 then Enter
    edit_sel = 3'd1;
    repeat (2) @(negedge clk);
    send(8'h2E);
`ifdef LIVE_UPDATE_EN
    chk("t6_f1_a", fld(1), 5);
    chk("t6_commit_a", c_s, 1);
`else
    chk("t6_f1_a", fld(1), 0);
`endif
    send(8'h26);
`ifdef LIVE_UPDATE_EN
    chk("t6_f1_b", fld(1), 53);
`endif
    chk("t6_buf_b", edit_buf, 8'h53);
    send(8'h26);
`ifdef LIVE_UPDATE_EN
    chk("t6_f1_c", fld(1), 33);
    chk("t6_commit_c", c_s, 1);
`endif
    chk("t6_buf_c", edit_buf, 8'h33);
    send(8'h5A);
    chk("t6_f1_final", fld(1), 33);
    chk("commit_err_exclusive", both_cnt, 0);
    chk("low_run_final", max_run, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
